return_address_stack: RTL
=========================

RETURN_ADDRESS_STACK -- requirements
Module: return_address_stack

Interface
REQ-001 Parameter DEPTH, default 8, number of stack entries; legal values are powers of two from 2 to 64.
REQ-002 Parameter WIDTH, default 16, address width in bits, matching the PC width.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  rising-edge clock shared with the PC module.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 call  in  1  CALL executed this cycle; push link address.
REQ-007 ret  in  1  RET executed this cycle; pop top entry.
REQ-008 stall  in  1  pipeline stall; freezes all state while high.
REQ-009 flush  in  1  synchronous clear of the stack contents and pointers.
REQ-010 pcIn  in  WIDTH  address of the CALL instruction.
REQ-011 returnAddress  out  WIDTH  current top-of-stack; feeds the PC RET source (R7 path).
REQ-012 empty  out  1  high when count == 0.
REQ-013 full  out  1  high when count == DEPTH.
REQ-014 overflow  out  1  sticky; a push occurred while full.
REQ-015 underflow  out  1  sticky; a pop occurred while empty.
REQ-016 count  out  log2(DEPTH)+1  number of valid entries.

Function
REQ-017 Storage: circular buffer of DEPTH x WIDTH entries, top pointer tp of width log2(DEPTH); the top entry is at tp-1 (mod DEPTH).
REQ-018 Link value: pcIn + 1, truncated modulo 2^WIDTH (0xFFFF + 1 = 0x0000).
REQ-019 Priority per rising edge: reset_n, then stall, then flush, then the call/ret combination.
REQ-020 stall=1: no state change, regardless of call, ret or flush.
REQ-021 flush=1 (no stall): tp=0, count=0; entry contents are don't-care; sticky flags are preserved.
REQ-022 Push only (call=1, ret=0): write the link value at tp, then tp=tp+1 mod DEPTH, count=min(count+1, DEPTH).
REQ-023 Push when full: the oldest entry is overwritten (wrap-around), count stays at DEPTH, and overflow is set.
REQ-024 Pop only (call=0, ret=1) with count>0: tp=tp-1 mod DEPTH, count=count-1.
REQ-025 Pop when empty: tp and count are unchanged and underflow is set.
REQ-026 call=1 and ret=1: the top entry is replaced with the link value in place; tp and count are unchanged.
REQ-027 call=1 and ret=1 with count==0: acts as a push (count becomes 1), underflow is set, and overflow is not affected.
REQ-028 returnAddress is combinational from the registered state, equal to entry[tp-1]; when empty it outputs 0.
REQ-029 Latency: a push is visible on returnAddress in the cycle after the clock edge; a pop exposes the previous entry in the cycle after the edge.
REQ-030 empty, full and count are registered-state decodes with no extra latency.
REQ-031 Sticky flags: once set, overflow and underflow are cleared only by reset_n.

Reset
REQ-032 Asserting reset_n low immediately forces tp=0, count=0, overflow=0, underflow=0, empty=1, full=0 and returnAddress=0, independent of clock.
REQ-033 Reset mid-operation discards any push or pop in flight; the first edge after deassertion behaves as on an empty stack.
REQ-034 Entry storage is not required to be reset.

Verification
REQ-035 After reset: call with pcIn=10 -> returnAddress=11, count=1; ret -> empty=1, returnAddress=0.
REQ-036 Calls with pcIn=0x0100, 0x0200, 0x0300, then three rets -> returnAddress reads 0x0301, then 0x0201, then 0x0101, then empty.
REQ-037 Nine calls with pcIn=1..9 (DEPTH=8) -> full=1 and overflow=1; eight rets then read 10,9,8,7,6,5,4,3; a ninth ret sets underflow, and count stays 0.
REQ-038 With top=0x0011, call+ret with pcIn=0x0040 in the same cycle -> returnAddress=0x0041, count unchanged; call with pcIn=0xFFFF -> returnAddress=0x0000.
REQ-039 Stall held while call=1 -> no change; flush -> empty=1 and sticky flags preserved; reset_n pulse between clock edges -> outputs reset immediately.

Source files
------------

// File: rtl/return_address_stack.sv
`default_nettype none
// ============================================================================
//  Module      : return_address_stack
//  Description : Hardware return-address stack for CALL/RET prediction.
//                A circular buffer of DEPTH link addresses with a top
//                pointer. A push writes pcIn+1. On overflow the oldest
//                entry is overwritten. A pop on an empty stack leaves the
//                pointers alone. Both cases raise sticky error flags.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock          in   rising-edge clock
//    reset_n        in   asynchronous active-low reset
//    call           in   CALL executed this cycle (push link address)
//    ret            in   RET executed this cycle (pop top entry)
//    stall          in   freezes all state while high
//    flush          in   synchronous clear of pointer and count
//    pcIn           in   address of the CALL instruction
//    returnAddress  out  current top of stack, 0 when empty
//    empty          out  count == 0
//    full           out  count == DEPTH
//    overflow       out  sticky: a push happened while full
//    underflow      out  sticky: a pop happened while empty
//    count          out  number of valid entries
// ============================================================================
module return_address_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       call,
  input  logic                       ret,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           pcIn,
  output logic [WIDTH-1:0]           returnAddress,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  // Reject illegal sizes at elaboration time.
  generate
    if ((DEPTH < 2) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("return_address_stack: DEPTH must be a power of two in 2..64");
    end
  endgenerate

  // Registered state
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_tp;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;

  // Derived combinational values
  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_wr_idx;
  logic [WIDTH-1:0] w_link;
  logic             w_empty;
  logic             w_full;
  logic             w_wr_en;

  assign w_top_idx = r_tp - PTR_W'(1);
  assign w_link    = pcIn + WIDTH'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_DEPTH);

  // call+ret on a non-empty stack replaces the top entry in place;
  // every other push writes at the free slot tp.
  assign w_wr_idx = (ret && !w_empty) ? w_top_idx : r_tp;
  assign w_wr_en  = reset_n && !stall && !flush && call;

  // Entry storage carries no reset: stale contents are never visible
  // because returnAddress is masked while the stack is empty.
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= w_link;
    end
  end

  // Pointer, occupancy and sticky flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tp        <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (!stall) begin
      if (flush) begin
        // Sticky flags deliberately survive a flush.
        r_tp    <= '0;
        r_count <= '0;
      end else begin
        case ({call, ret})
          2'b10: begin
            // Push. When full, tp already points at the oldest entry,
            // so the write overwrites it and the count saturates.
            r_tp <= r_tp + PTR_W'(1);
            if (w_full) begin
              r_overflow <= 1'b1;
            end else begin
              r_count <= r_count + CNT_W'(1);
            end
          end
          2'b01: begin
            if (w_empty) begin
              r_underflow <= 1'b1;
            end else begin
              r_tp    <= w_top_idx;
              r_count <= r_count - CNT_W'(1);
            end
          end
          2'b11: begin
            // Replace-in-place; on an empty stack the pop half underflows
            // and the push half still lands as the single entry.
            if (w_empty) begin
              r_tp        <= r_tp + PTR_W'(1);
              r_count     <= CNT_W'(1);
              r_underflow <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign returnAddress = w_empty ? '0 : r_mem[w_top_idx];
  assign empty         = w_empty;
  assign full          = w_full;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;
  assign count         = r_count;

endmodule
`default_nettype wire
